dm_cache_controller: RTL
========================

Name: dm_cache_controller

Overview:
- Direct-mapped write-back cache controller between the CPU load/store port and the block-wide data memory.
- Holds the valid, dirty, tag and data arrays for 8 lines of 4 bytes each.
- Sequences tag comparison, hit service, dirty-line write-back and line fill.
- Stalls the CPU through busywait until each access completes.

Parameters:
- TAG_W, 3, address tag width
- INDEX_W, 3, line index width (2^INDEX_W lines)
- OFFSET_W, 2, byte offset width (2^OFFSET_W bytes per line)
- BYTE_W, 8, CPU data width

Ports:
- clock, input, 1, single clock; all state updates on posedge
- reset, input, 1, asynchronous, active-low; 0 clears all state immediately
- read, input, 1, CPU load request
- write, input, 1, CPU store request
- address, input, 8, {tag[7:5], index[4:2], offset[1:0]}
- writedata, input, 8, CPU store byte
- readdata, output, 8, CPU load byte
- busywait, output, 1, CPU stall
- mem_read, output, 1, memory block read strobe
- mem_write, output, 1, memory block write strobe
- mem_address, output, 6, memory block address {tag, index}
- mem_writedata, output, 32, block written back to memory
- mem_readdata, input, 32, block returned by memory
- mem_busywait, input, 1, memory busy

Behaviour:
- Reset (reset=0), asynchronous:
  - all valid and dirty bits are 0; state is IDLE.
  - busywait, mem_read and mem_write are 0; readdata is 0.
  - mem_address and mem_writedata are 0.
  - Tag and data arrays are don't-care.
- Definitions:
  - hit = valid[index] & (tag_array[index] == address tag), combinational.
  - req = read | write. If read and write are both 1, the access is treated as a write.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE, read hit:
  - readdata = data[index][offset] combinationally; busywait=0.
  - Zero added cycles.
- IDLE, write hit:
  - busywait=0.
  - At posedge, the byte is written into data[index][offset] and dirty[index]=1.
  - Memory is not touched.
- IDLE, miss (req & !hit):
  - busywait=1 combinationally in the same cycle.
  - At posedge: goes to WRITEBACK if valid & dirty, else to FETCH.
- WRITEBACK:
  - mem_write=1, mem_address={tag_array[index], index}, mem_writedata=data[index].
  - Memory raises mem_busywait in response. The state is held for at least one cycle.
  - Goes to FETCH at the first later posedge with mem_busywait=0.
- FETCH:
  - mem_read=1, mem_address={address tag, index}.
  - Same handshake rule as WRITEBACK; goes to UPDATE.
- UPDATE (one cycle):
  - data[index]=mem_readdata, tag_array[index]=address tag, valid=1, dirty=0.
  - Returns to IDLE. The access is then re-evaluated and completes as a hit.
- busywait:
  - Is 1 in WRITEBACK, FETCH and UPDATE.
  - Is 1 in IDLE only on a miss.
- mem_read and mem_write are never 1 together, and are both 0 outside WRITEBACK/FETCH.
- Address and request are held stable by the CPU while busywait=1. If req drops mid-miss, the in-flight fill still completes and the controller then idles.
- Reset asserted mid-WRITEBACK or mid-FETCH:
  - immediate IDLE; strobes drop; all lines become invalid.
  - The partial memory transaction is abandoned; no data loss is guaranteed.
- Miss penalty: clean miss = 1 (IDLE) + fetch cycles + 1 (UPDATE) + 1 hit cycle. A dirty miss adds the write-back cycles.

Decomposition:
- Shared package cache_pkg holds:
  - state encoding: IDLE=2'd0, WRITEBACK=2'd1, FETCH=2'd2, UPDATE=2'd3.
  - field widths TAG_W, INDEX_W, OFFSET_W, BLOCK_W=32.
  - address field slice positions.
- One natural sub-module: line_hit_check, taking valid, stored tag and address tag and producing hit. It is instantiated once on the indexed line.
- The FSM and arrays stay in the top module.

Test Plan:
- Reset, then read address 0x14 with memory returning 0xDDCCBBAA after 5 busy cycles:
  - busywait high, mem_read=1, mem_address=6'b000101.
  - After UPDATE: readdata=0xAA (offset 0), busywait low.
  - Repeat read of 0x15 returns 0xBB with no stall.
- Write 0x5A to 0x14 after the fill: no stall, mem strobes stay 0, dirty[5]=1. A subsequent read of 0x14 returns 0x5A.
- Read 0xB4 (same index 5, tag 3'b101) while the line is dirty:
  - WRITEBACK first: mem_write=1, mem_address=6'b000101, mem_writedata=0xDDCCBB5A.
  - Then FETCH with mem_address=6'b101101; the two strobes are never high together.
- Read 0x30 (index 4, invalid): goes directly to FETCH with no WRITEBACK cycle.
- Reset pulsed low mid-FETCH: mem_read and busywait drop asynchronously; state returns to IDLE. A re-read of a previously filled address misses.
- read=1 and write=1 together on a hit: handled as a write, with writedata stored and readdata ignored.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache controller:
// FSM state encoding, field widths and address slice positions.
package cache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int BYTE_W   = 8;
    localparam int BLOCK_W  = 32;

    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int TAG_LSB    = OFFSET_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

endpackage

// File: rtl/line_hit_check.sv
// Tag comparison for the currently indexed cache line.
module line_hit_check
    import cache_pkg::*;
#(
    parameter int TAG_W = cache_pkg::TAG_W
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] stored_tag,
    input  logic [TAG_W-1:0] addr_tag,
    output logic             hit
);

    assign hit = valid && (stored_tag == addr_tag);

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped write-back cache: tag/data arrays plus the miss FSM that
// sequences write-back of dirty victims and line fill from block memory.
module dm_cache_controller
    import cache_pkg::*;
#(
    parameter int TAG_W    = cache_pkg::TAG_W,
    parameter int INDEX_W  = cache_pkg::INDEX_W,
    parameter int OFFSET_W = cache_pkg::OFFSET_W,
    parameter int BYTE_W   = cache_pkg::BYTE_W
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                read,
    input  logic                                write,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0]   address,
    input  logic [BYTE_W-1:0]                   writedata,
    output logic [BYTE_W-1:0]                   readdata,
    output logic                                busywait,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [TAG_W+INDEX_W-1:0]            mem_address,
    output logic [(BYTE_W<<OFFSET_W)-1:0]       mem_writedata,
    input  logic [(BYTE_W<<OFFSET_W)-1:0]       mem_readdata,
    input  logic                                mem_busywait
);

    localparam int LINES = 1 << INDEX_W;
    localparam int BLK_W = BYTE_W << OFFSET_W;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;

    assign addr_tag = address[OFFSET_W+INDEX_W +: TAG_W];
    assign idx      = address[OFFSET_W +: INDEX_W];
    assign off      = address[OFFSET_W-1:0];

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [BLK_W-1:0] data_q [LINES];
    logic [BLK_W-1:0] fill_buf;

    state_t state, next_state;
    logic   hit;
    logic   req;
    logic   hit_write;
    logic [BLK_W-1:0] line_block;

    line_hit_check #(.TAG_W(TAG_W)) u_hit (
        .valid      (valid_q[idx]),
        .stored_tag (tag_q[idx]),
        .addr_tag   (addr_tag),
        .hit        (hit)
    );

    // A request seen while reset is low must not raise busywait.
    assign req        = (read | write) & reset;
    assign line_block = data_q[idx];

    always_comb begin
        next_state    = state;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        readdata      = '0;
        hit_write     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        hit_write = write;
                        if (!write)
                            readdata = line_block[off*BYTE_W +: BYTE_W];
                    end else begin
                        busywait   = 1'b1;
                        next_state = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {tag_q[idx], idx};
                mem_writedata = line_block;
                if (!mem_busywait)
                    next_state = FETCH;
            end
            FETCH: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {addr_tag, idx};
                if (!mem_busywait)
                    next_state = UPDATE;
            end
            UPDATE: begin
                busywait   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state <= next_state;
            if (hit_write)
                dirty_q[idx] <= 1'b1;
            if (state == UPDATE) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // The fill block is captured as memory completes, since mem_address
    // (and so the memory's output) is released in UPDATE.
    always_ff @(posedge clock) begin
        if (hit_write)
            data_q[idx][off*BYTE_W +: BYTE_W] <= writedata;
        if (state == FETCH && !mem_busywait)
            fill_buf <= mem_readdata;
        if (state == UPDATE) begin
            data_q[idx] <= fill_buf;
            tag_q[idx]  <= addr_tag;
        end
    end

endmodule
